seq_det_ctrl: RTL and testbench

- Programmable controller for the team's serial bit-sequence detectors.
- Holds pattern, length and match-threshold configuration and runs a Mealy-style detector on a valid-qualified serial stream. Detection is overlapping by default.
- Counts matches and sequences the run through IDLE/ARM/RUN/DONE.
- Lets one software-visible block replace fixed-pattern detectors such as the "11" detector.

---
 rtl/seq_det_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Programmable serial bit-sequence detector with run sequencing (IDLE/ARM/RUN/DONE) and match counting.
// Latency: match is combinational in the cycle of the completing bit; count/state update on the next edge.
// Backpressure: none; in_valid qualifies each serial bit and every valid bit in RUN is consumed.
// Optional build macro SEQ_DET_CTRL_NONOVERLAP_EN selects non-overlapping detection (default: overlapping).
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [4:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic               in,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0]         LEN_MAX = 5'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] PAT_RST = {{(MAX_LEN-2){1'b0}}, 2'b11};

    state_t             r_state;
    state_t             w_state_nxt;

    // configuration, writable only while no run is in progress
    logic [MAX_LEN-1:0] r_pattern;
    logic [4:0]         r_len;
    logic [CNT_W-1:0]   r_thresh;

    // detector datapath
    logic [MAX_LEN-1:0] r_hist;
    logic [4:0]         r_fill;
    logic [CNT_W-1:0]   r_cnt;

    logic [4:0]         w_len_clamp;
    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_cand;
    logic               w_hit;
    logic               w_cfg_ok;
    logic               w_accept;
    logic [CNT_W:0]     w_cnt_p1;
    logic               w_thresh_hit;

    // clamp requested length into the supported range 2..MAX_LEN
    always_comb begin
        w_len_clamp = cfg_len;
        if (cfg_len < 5'd2) begin
            w_len_clamp = 5'd2;
        end else if (cfg_len > LEN_MAX) begin
            w_len_clamp = LEN_MAX;
        end
    end

    // mask selecting the low r_len bits of candidate and pattern
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (5'(i) < r_len);
        end
    end

    // candidate window: stored history with the incoming bit appended as bit 0
    assign w_cand = {r_hist[MAX_LEN-2:0], in};

    // enough bits seen and the masked window equals the masked pattern
    assign w_hit = (r_fill >= (r_len - 5'd1)) &&
                   ((w_cand & w_mask) == (r_pattern & w_mask));

    assign w_cfg_ok     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept     = (r_state == S_RUN) && in_valid && !stop;
    assign w_cnt_p1     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_thresh_hit = (r_thresh != '0) && (w_cnt_p1 == {1'b0, r_thresh});

    assign match_cnt = r_cnt;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state and Mealy outputs; stop dominates inside a run, start dominates outside
    always_comb begin
        w_state_nxt = r_state;
        match       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                busy = 1'b1;
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (in_valid && w_hit) begin
                    match = 1'b1;
                    if (w_thresh_hit) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt = S_ARM;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // configuration registers; writes during ARM/RUN are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= PAT_RST;
            r_len     <= 5'd2;
            r_thresh  <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cfg_we && w_cfg_ok) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_clamp;
            r_thresh  <= cfg_thresh;
        end
    end

    // history, fill level and saturating match counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_ARM) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_hist <= w_cand;
            if (r_fill < r_len) begin
                r_fill <= r_fill + 5'd1;
            end
            if (match) begin
                if (r_cnt != '1) begin
                    r_cnt <= w_cnt_p1[CNT_W-1:0];
                end
`ifdef SEQ_DET_CTRL_NONOVERLAP_EN
                // a counted match consumes its bits: the next match needs a full fresh window
                r_hist <= '0;
                r_fill <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: stimulus queues expected match events, a monitor pops them on each match pulse.
// Latency: match checked at the negedge of the completing bit; status checked 1 time unit after each edge.
// Backpressure: not applicable; stimulus drives in_valid directly.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [4:0] cfg_len;
    logic [7:0] cfg_thresh;
    logic       start;
    logic       stop;
    logic       in_valid;
    logic       d_in;

    logic       match;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;

    logic       m2_match;
    logic [1:0] m2_cnt;
    logic       m2_busy;
    logic       m2_done;

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   cur_id;
    int   checks;
    int   errors;

`ifdef SEQ_DET_CTRL_NONOVERLAP_EN
    localparam bit NONOVL = 1'b1;
`else
    localparam bit NONOVL = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .start(start), .stop(stop),
        .in_valid(in_valid), .in(d_in), .match(match), .match_cnt(match_cnt),
        .busy(busy), .done(done)
    );

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh[1:0]), .start(start), .stop(stop),
        .in_valid(in_valid), .in(d_in), .match(m2_match), .match_cnt(m2_cnt),
        .busy(m2_busy), .done(m2_done)
    );

    // monitor: every match pulse must correspond to the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && match) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_match id=%0d got match=1 cnt=%0d, required no match", cur_id, match_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.id != cur_id || e.cnt != int'(match_cnt)) begin
                    errors++;
                    $display("FAIL match_event got id=%0d cnt=%0d, required id=%0d cnt=%0d",
                             cur_id, match_cnt, e.id, e.cnt);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic sb_drain(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s missing matches got %0d outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic send(input logic b, input int id, input bit exp_m, input int exp_cnt);
        if (exp_m) sb.push_back('{id, exp_cnt});
        cur_id   = id;
        in_valid = 1'b1;
        d_in     = b;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic gap(input int id);
        cur_id   = id;
        in_valid = 1'b0;
        d_in     = 1'b1;
        cyc();
    endtask

    task automatic cfg(input logic [7:0] p, input logic [4:0] l, input logic [7:0] t);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_thresh = t;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic run_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    initial begin
        checks = 0; errors = 0; cur_id = 0;
        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
        start = 1'b0; stop = 1'b0; in_valid = 1'b0; d_in = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_match", int'(match), 0);
        chk("rst_cnt", int'(match_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        // default "11", thresh 1: stream 0,1,1,1
        run_start();
        chk("t1_busy_run", int'(busy), 1);
        send(1'b0, 1, 0, 0);
        send(1'b1, 2, 0, 0);
        send(1'b1, 3, 1, 0);
        chk("t1_done", int'(done), 1);
        chk("t1_cnt", int'(match_cnt), 1);
        send(1'b1, 4, 0, 0);
        chk("t1_cnt_held", int'(match_cnt), 1);
        sb_drain("t1");

        // pattern 101 len 3 thresh 0: stream 1,0,1,0,1
        cfg(8'b101, 5'd3, 8'd0);
        run_start();
        send(1'b1, 11, 0, 0);
        send(1'b0, 12, 0, 0);
        send(1'b1, 13, 1, 0);
        send(1'b0, 14, 0, 0);
        send(1'b1, 15, !NONOVL, 1);
        chk("t2_cnt", int'(match_cnt), NONOVL ? 1 : 2);
        chk("t2_busy", int'(busy), 1);
        sb_drain("t2");
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t2_stop_busy", int'(busy), 0);

        // "11" thresh 0 with a 3-cycle gap, then up to cnt 3 and stop on a completing bit
        cfg(8'b11, 5'd2, 8'd0);
        run_start();
        send(1'b1, 21, 0, 0);
        gap(22); gap(22); gap(22);
        send(1'b1, 23, 1, 0);
        send(1'b0, 24, 0, 0);
        send(1'b1, 25, 0, 0);
        send(1'b1, 26, 1, 1);
        send(1'b0, 27, 0, 0);
        send(1'b1, 28, 0, 0);
        send(1'b1, 29, 1, 2);
        chk("t4_cnt_before_stop", int'(match_cnt), 3);
        stop = 1'b1;
        send(1'b1, 30, 0, 0);
        stop = 1'b0;
        chk("t4_cnt_after_stop", int'(match_cnt), 3);
        chk("t4_busy", int'(busy), 0);
        chk("t4_done", int'(done), 0);
        sb_drain("t3_t4");

        // write during RUN ignored; old "11" still detected
        run_start();
        cfg(8'b10110, 5'd5, 8'd0);
        send(1'b1, 41, 0, 0);
        send(1'b1, 42, 1, 0);
        stop = 1'b1; cyc(); stop = 1'b0;
        sb_drain("t5_ignore");

        // len 20 clamps to 8: only the full 8-bit window 00000011 matches
        cfg(8'b00000011, 5'd20, 8'd1);
        run_start();
        send(1'b1, 51, 0, 0);
        send(1'b1, 52, 0, 0);
        for (int i = 0; i < 6; i++) send(1'b0, 53 + i, 0, 0);
        send(1'b1, 59, 0, 0);
        send(1'b1, 60, 1, 0);
        chk("t5_clamp_done", int'(done), 1);
        chk("t5_clamp_cnt", int'(match_cnt), 1);
        sb_drain("t5_clamp");

        // saturation: 6 ones on "11", thresh 0; CNT_W=2 instance saturates at 3
        rst = 1'b1; cyc(); rst = 1'b0;
        cfg(8'b11, 5'd2, 8'd0);
        run_start();
        send(1'b1, 61, 0, 0);
        for (int i = 0; i < 5; i++) send(1'b1, 62 + i, 1, i);
        chk("t6_cnt8", int'(match_cnt), 5);
        chk("t6_cnt2_sat", int'(m2_cnt), 3);
        sb_drain("t6");

        // reset mid-run with a completing bit present
        rst = 1'b1; in_valid = 1'b1; d_in = 1'b1; cur_id = 70;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("t6_rst_match", int'(match), 0);
        chk("t6_rst_cnt", int'(match_cnt), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_cnt2", int'(m2_cnt), 0);
        chk("t6_rst_busy2", int'(m2_busy), 0);

        // configuration back to "11", thresh 1
        run_start();
        send(1'b1, 71, 0, 0);
        send(1'b1, 72, 1, 0);
        chk("t6_post_done", int'(done), 1);
        chk("t6_post_cnt", int'(match_cnt), 1);
        chk("t6_post_done2", int'(m2_done), 1);
        sb_drain("t6_post");

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
